ram_dump_tx: RTL and testbench
==============================

// Module: ram_dump_tx
// PURPOSE
//  Reader-side counterpart of the FPGA memory loader. On a start pulse it takes
//  the RAM data port away from the CPU and reads a block of 32-bit words from RAM.
//  Each word goes out as 4 bytes, LSB first, over the byte-wide UART transmit
//  handshake (txdata/txclk/txready). An optional XOR checksum byte follows the
//  last word. Sits beside the loader in top1 and shares the same RAM data-port muxes.
// PARAMETERS
//  ADDR_W     12  RAM byte-address width; address arithmetic wraps mod 2**ADDR_W
//  CNT_W      10  width of word_count (max 1023 words)
//  READ_LAT   1   cycles from mem_addr valid to mem_rdata valid
//  SEND_CSUM  1   1: append XOR-8 of all sent bytes after the last word
// PORTS
//  clk         in   1      system clock
//  nrst        in   1      synchronous active-low reset
//  start       in   1      one-cycle request; sampled only in IDLE
//  base_addr   in   ADDR_W byte address of first word; bits [1:0] ignored (forced 0)
//  word_count  in   CNT_W  number of words to send; sampled with start
//  mem_en      out  1      1 = this block owns RAM data port (drives addr mux select)
//  mem_addr    out  32     RAM data address, zero-extended from ADDR_W
//  mem_rdata   in   32     RAM data_out (memload)
//  cpu_enable  out  1      0 while busy: PC is frozen
//  txdata      out  8      byte to transmit
//  txclk       out  1      byte valid; held with txdata stable until txready
//  txready     in   1      UART accepts byte in any cycle where txclk&&txready
//  busy        out  1      high from the cycle after accepted start until DONE exits
//  done        out  1      one-cycle pulse after the final byte is accepted
// BEHAVIOUR
//  Reset (nrst=0 at clk edge): state IDLE; mem_en=0, mem_addr=0, cpu_enable=1,
//   txdata=0, txclk=0, busy=0, done=0, checksum=0. Reset mid-dump aborts at once.
//   The partly sent word is dropped and the bus is released next cycle.
//  Every state-machine output is registered.
//  States:
//   IDLE:  start=1 and word_count!=0 -> latch addr={base_addr[ADDR_W-1:2],2'b00}
//          and remaining=word_count; clear checksum -> ADDR.
//          start=1 and word_count==0 -> pulse done for 1 cycle, stay IDLE.
//          busy stays 0 and nothing is sent.
//   ADDR:  mem_en=1, cpu_enable=0, mem_addr=addr; load wait counter=READ_LAT -> WAIT.
//   WAIT:  count down; at 0 capture mem_rdata into word register, byte index=0 -> SEND.
//   SEND:  txclk=1, txdata=word[8*idx+:8]. On txready: checksum^=txdata.
//          If idx<3, idx++ with txclk kept high, so back-to-back bytes are allowed.
//          If idx==3: remaining--; addr+=4 (wraps mod 2**ADDR_W);
//          remaining!=0 -> ADDR; otherwise SEND_CSUM ? CSUM : DONE.
//   CSUM:  txclk=1, txdata=checksum; on txready -> DONE.
//   DONE:  txclk=0, mem_en=0, cpu_enable=1, done=1 for exactly one cycle -> IDLE.
//  Bus ownership:
//   mem_en stays asserted from ADDR through SEND/CSUM. RAM write_enable is never
//   driven by this block; its mux leg must be tied to 0.
//  Boundary rules:
//   - start while busy: ignored.
//   - txready high with txclk low: no effect.
//   - txready held high: one byte per cycle.
//   - Throughput: 4 bytes per word, plus ADDR+WAIT overhead of 1+READ_LAT cycles.
//   - Wrap: a block crossing the top of RAM continues at address 0.
//   - word_count = 2**CNT_W-1 must complete without counter overflow.
// STRUCTURE
//  Package stars_dump_pkg:
//   - dump_state_t enum {IDLE, ADDR, WAIT, SEND, CSUM, DONE}
//   - BYTES_PER_WORD=4, ADDR_STRIDE=4
//  Sub-module tx_byte_sel: registered 32->8 byte selector with idx counter and
//   the valid/ready hold logic. Reused later for the register-dump path.
//  Top-level wiring: mem_en ORs into FPGAEnable select; mem_addr feeds the
//   address mux; cpu_enable ANDs with the loader's CPUEnable.
// TESTING
//  1 RAM[0x100]=0x11223344, start, base=0x100, cnt=1, txready=1 ->
//    bytes 44,33,22,11,CS=0x44; done 1 cycle later; mem_en low after done.
//  2 cnt=3 from 0x200, txready toggling 1-in-3 cycles -> 12 bytes in order, txdata
//    stable while txclk&&!txready, no byte lost or duplicated.
//  3 base=0xFFC, cnt=2 -> mem_addr 0xFFC then 0x000; 8 bytes from RAM[0xFFC],RAM[0].
//  4 start with cnt=0 -> done pulse next cycle, txclk never rises, busy stays 0.
//  5 nrst low while idx=2 of word 1 -> next cycle all outputs at reset values.
//    A subsequent start dumps correctly from scratch.
//  6 second start during SEND -> ignored; base=0x103 -> reads from 0x100.

Source files
------------

// File: rtl/ram_dump_tx_pkg.sv
// Shared types for the RAM dump transmitter.
//   dump_state_t   : dump sequencer states
//   BYTES_PER_WORD : bytes sent per 32-bit RAM word
//   ADDR_STRIDE    : byte-address step between consecutive words
package stars_dump_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, CSUM, DONE} dump_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STRIDE    = 4;
endpackage

// File: rtl/ram_dump_tx_byte_sel.sv
// tx_byte_sel: registered 32->8 byte serializer for a valid/ready byte link.
// A load captures a 32-bit value and the index of its last byte. Bytes are
// then presented LSB first on txdata with txclk high. A byte advances only
// when txclk&&ready. A load overrides whatever is in flight.
//   clk, nrst    : clock, synchronous active-low reset
//   load         : capture data/last_idx_in and start presenting byte 0
//   data         : value to serialize
//   last_idx_in  : index of final byte (3 = full word, 0 = single byte)
//   ready        : sink accepts the presented byte this cycle
//   txdata/txclk : registered byte and valid
//   fire         : byte accepted this cycle
//   last         : final byte accepted this cycle
module tx_byte_sel (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [1:0]  last_idx_in,
  input  logic        ready,
  output logic [7:0]  txdata,
  output logic        txclk,
  output logic        fire,
  output logic        last
);
  logic [31:0] word;
  logic [1:0]  idx, last_idx, idx_inc;

  assign fire    = txclk & ready;
  assign last    = fire & (idx == last_idx);
  assign idx_inc = idx + 2'd1;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      word     <= '0;
      idx      <= '0;
      last_idx <= '0;
      txdata   <= '0;
      txclk    <= 1'b0;
    end else if (load) begin
      word     <= data;
      idx      <= '0;
      last_idx <= last_idx_in;
      txdata   <= data[7:0];
      txclk    <= 1'b1;
    end else if (last) begin
      txdata   <= '0;
      txclk    <= 1'b0;
    end else if (fire) begin
      // txclk stays high so the next byte can go out back-to-back
      idx      <= idx_inc;
      txdata   <= word[{idx_inc, 3'b000} +: 8];
    end
  end
endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: on start, takes the RAM data port from the CPU and streams a
// block of 32-bit words out over the UART byte handshake, LSB first, with an
// optional XOR-8 checksum byte appended.
//   clk, nrst            : clock, synchronous active-low reset
//   start                : dump request, honoured only when idle
//   base_addr            : byte address of first word (low two bits dropped)
//   word_count           : words to send; 0 just pulses done
//   mem_en, mem_addr     : RAM data-port ownership and read address
//   mem_rdata            : RAM read data, READ_LAT cycles after mem_addr
//   cpu_enable           : low while this block owns the RAM port
//   txdata, txclk        : byte stream to UART (held until txready)
//   txready              : UART accepts the byte when txclk&&txready
//   busy                 : dump in progress
//   done                 : one-cycle completion pulse
module ram_dump_tx
  import stars_dump_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int CNT_W     = 10,
  parameter int READ_LAT  = 1,
  parameter int SEND_CSUM = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_en,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_enable,
  output logic [7:0]        txdata,
  output logic              txclk,
  input  logic              txready,
  output logic              busy,
  output logic              done
);
  localparam int LAT_W = $clog2(READ_LAT + 1);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [CNT_W-1:0]  remaining, remaining_nxt;
  logic [LAT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [7:0]        csum, csum_nxt;
  logic              ld;
  logic [31:0]       ld_data;
  logic [1:0]        ld_last;
  logic              fire, last;
  logic              done_zero, done_nxt, owns_nxt;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^base_addr[1:0];

  tx_byte_sel u_sel (
    .clk         (clk),
    .nrst        (nrst),
    .load        (ld),
    .data        (ld_data),
    .last_idx_in (ld_last),
    .ready       (txready),
    .txdata      (txdata),
    .txclk       (txclk),
    .fire        (fire),
    .last        (last)
  );

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    wait_cnt_nxt  = wait_cnt;
    csum_nxt      = csum;
    ld            = 1'b0;
    ld_data       = mem_rdata;
    ld_last       = 2'(BYTES_PER_WORD - 1);
    done_zero     = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (word_count != '0) begin
          addr_nxt      = {base_addr[ADDR_W-1:2], 2'b00};
          remaining_nxt = word_count;
          csum_nxt      = '0;
          state_nxt     = ADDR;
        end else begin
          done_zero = 1'b1;
        end
      end
      ADDR: begin
        wait_cnt_nxt = LAT_W'(READ_LAT);
        state_nxt    = WAIT;
      end
      // WAIT lasts READ_LAT cycles; rdata is valid in the last of them
      WAIT: begin
        if (wait_cnt == LAT_W'(1)) begin
          ld        = 1'b1;
          state_nxt = SEND;
        end else begin
          wait_cnt_nxt = wait_cnt - LAT_W'(1);
        end
      end
      SEND: begin
        if (fire) csum_nxt = csum ^ txdata;
        if (last) begin
          remaining_nxt = remaining - CNT_W'(1);
          addr_nxt      = addr + ADDR_W'(ADDR_STRIDE);
          if (remaining != CNT_W'(1)) begin
            state_nxt = ADDR;
          end else if (SEND_CSUM != 0) begin
            // checksum must include the byte accepted this cycle
            ld        = 1'b1;
            ld_data   = {24'h0, csum_nxt};
            ld_last   = 2'd0;
            state_nxt = CSUM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      CSUM: if (fire) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    done_nxt = done_zero | (state_nxt == DONE);
    owns_nxt = (state_nxt == ADDR) | (state_nxt == WAIT) |
               (state_nxt == SEND) | (state_nxt == CSUM);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      wait_cnt   <= '0;
      csum       <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      cpu_enable <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      remaining  <= remaining_nxt;
      wait_cnt   <= wait_cnt_nxt;
      csum       <= csum_nxt;
      mem_en     <= owns_nxt;
      cpu_enable <= ~owns_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      // address only moves on entering ADDR so it is stable through WAIT/SEND
      if (state_nxt == ADDR) mem_addr <= 32'(addr_nxt);
      else if (!owns_nxt)    mem_addr <= '0;
    end
  end
endmodule

// File: tb/tb_ram_dump_tx.sv
module tb_ram_dump_tx;
  logic        clk, nrst, start, txready, mem_en, cpu_enable, txclk, busy, done;
  logic [11:0] base_addr;
  logic [9:0]  word_count;
  logic [31:0] mem_addr, mem_rdata;
  logic [7:0]  txdata;

  logic [31:0] ram [1024];
  logic [7:0]  got[$];
  logic [31:0] addrs[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, rdy_pct = 100, n_done = 0, n_txclk = 0, done_cyc = 0, last_acc = 0;
  bit hold_pend = 0;
  logic [7:0] hold_data;

  ram_dump_tx dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cpu_enable(cpu_enable), .txdata(txdata),
    .txclk(txclk), .txready(txready), .busy(busy), .done(done)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= ram[mem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // UART sink: picks txready for the coming edge and logs accepted bytes
  initial begin
    txready = 0;
    forever begin
      @(negedge clk);
      if (hold_pend && nrst) begin
        chk("hold_clk", txclk, 1);
        chk("hold_data", txdata, hold_data);
      end
      if (txclk) n_txclk++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (mem_en && (addrs.size() == 0 || addrs[$] != mem_addr)) addrs.push_back(mem_addr);
      txready = ($urandom_range(0, 99) < rdy_pct);
      if (txclk && txready) begin got.push_back(txdata); last_acc = cyc; end
      hold_pend = txclk && !txready;
      hold_data = txdata;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_cpu_en"}, cpu_enable, 1);
    chk({tag, "_txdata"}, txdata, 0);
    chk({tag, "_txclk"}, txclk, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_dump(input int base, input int cnt, input int pct, input bit poke);
    int exp_b[$];
    int exp_a[$];
    logic [7:0] cs;
    int a, budget;
    bit seen, poked;
    cs = 0; a = base & 'hFFC;
    for (int k = 0; k < cnt; k++) begin
      exp_a.push_back(a);
      for (int b = 0; b < 4; b++) begin
        exp_b.push_back((ram[a >> 2] >> (8 * b)) & 'hFF);
        cs ^= 8'((ram[a >> 2] >> (8 * b)) & 'hFF);
      end
      a = (a + 4) % 4096;
    end
    if (cnt > 0) exp_b.push_back(cs);
    rdy_pct = pct;
    @(negedge clk); #1;
    got.delete(); addrs.delete(); n_done = 0; n_txclk = 0;
    start = 1; base_addr = 12'(base); word_count = 10'(cnt);
    @(negedge clk); #1;
    start = 0;
    if (cnt == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      @(negedge clk); #1;
      chk("zero_done_end", done, 0);
      chk("zero_txclk", n_txclk, 0);
      return;
    end
    chk("busy_rise", busy, 1);
    budget = 50 + cnt * 60;
    seen = 0; poked = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      start = 0;
      if (done) seen = 1;
      else if (poke && !poked && got.size() >= 1) begin
        start = 1; base_addr = 12'($urandom); word_count = 10'd5; poked = 1;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_latency", done_cyc, last_acc + 1);
    chk("done_mem_en", mem_en, 0);
    chk("done_cpu_en", cpu_enable, 1);
    chk("done_txclk", txclk, 0);
    @(negedge clk); #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_count", n_done, 1);
    chk("byte_count", got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) chk("byte", got[i], exp_b[i]);
    chk("addr_count", addrs.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < addrs.size(); i++) chk("addr", addrs[i], exp_a[i]);
  endtask

  initial begin
    bit ok;
    nrst = 0; start = 0; base_addr = 0; word_count = 0;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    ram['h100 >> 2] = 32'h11223344;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    nrst = 1;

    // single word, checksum 44^33^22^11 = 44
    run_dump('h100, 1, 100, 0);
    if (got.size() == 5) begin
      chk("t1_b0", got[0], 8'h44);
      chk("t1_b3", got[3], 8'h11);
      chk("t1_cs", got[4], 8'h44);
    end else chk("t1_len", got.size(), 5);

    run_dump('h200, 3, 33, 0);          // slow sink, hold checks
    run_dump('hFFC, 2, 70, 0);          // wraps to 0
    run_dump('h040, 0, 100, 0);         // zero count
    run_dump('h103, 3, 50, 1);          // unaligned base, start while busy

    // abort mid-word: reset while byte 2 of the second word is presented
    rdy_pct = 100;
    @(negedge clk); #1;
    got.delete();
    start = 1; base_addr = 12'h300; word_count = 10'd2;
    @(negedge clk); #1;
    start = 0;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk); #1;
      if (got.size() >= 7) ok = 1;
    end
    chk("abort_reached", ok, 1);
    nrst = 0;
    @(negedge clk); #1;
    check_reset_vals("abort");
    nrst = 1;
    run_dump('h300, 2, 100, 0);

    for (int t = 0; t < 6; t++)
      run_dump($urandom_range(0, 4095), $urandom_range(1, 8), $urandom_range(25, 100), 0);

    run_dump('h010, 1023, 100, 0);      // full count, wraps the whole RAM

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
